// File: rtl/aurora_tx_gearbox.sv
// 66b -> 32b transmit gearbox: pulls blocks on demand, inserts idles when the
// source is dry, and optionally scrambles the payload with 1+x^39+x^58.
`timescale 1ns/1ps

module aurora_tx_gearbox #(
  parameter int unsigned SCRAMBLE  = 1,
  parameter logic [63:0] IDLE_DATA = 64'h7800_0000_0000_0000,
  parameter logic [1:0]  IDLE_HDR  = 2'b10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        out_en_i,
  input  logic        in_valid_i,
  input  logic [1:0]  in_header_i,
  input  logic [63:0] in_data_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_dv_o,
  output logic [5:0]  gbox_cnt_o,
  output logic        idle_ins_o
);

  // buf_q is MSB-aligned; the bits below the fill level are always zero.
  logic [96:0] buf_q, buf_d;
  logic [6:0]  fill_q, fill_d;
  logic [57:0] scr_q, scr_d;
  logic [5:0]  cnt_q;

  logic        load;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_pay, blk_tx;
  logic [96:0] blk_al, merged;

  assign load       = out_en_i && (fill_q < 7'd32);
  assign in_ready_o = load && in_valid_i;
  assign blk_hdr    = in_valid_i ? in_header_i : IDLE_HDR;
  assign blk_pay    = in_valid_i ? in_data_i : IDLE_DATA;

  // Whole 64-bit scramble is unrolled so the block leaves in its load cycle.
  always_comb begin
    scr_d  = scr_q;
    blk_tx = blk_pay;
    if (SCRAMBLE != 0) begin
      for (int i = 63; i >= 0; i--) begin
        blk_tx[i] = blk_pay[i] ^ scr_d[38] ^ scr_d[57];
        scr_d     = {scr_d[56:0], blk_tx[i]};
      end
    end
    if (!load) begin
      scr_d = scr_q;
    end
  end

  always_comb begin
    blk_al = '0;
    if (load) begin
      blk_al = {blk_hdr, blk_tx, 31'b0} >> fill_q;
    end
    merged = buf_q | blk_al;
    buf_d  = merged << 32;
    fill_d = fill_q + (load ? 7'd66 : 7'd0) - 7'd32;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q      <= '0;
      fill_q     <= '0;
      scr_q      <= '1;
      cnt_q      <= '0;
      out_data_o <= '0;
      out_dv_o   <= 1'b0;
      gbox_cnt_o <= '0;
      idle_ins_o <= 1'b0;
    end else if (out_en_i) begin
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      scr_q      <= scr_d;
      out_data_o <= merged[96:65];
      out_dv_o   <= 1'b1;
      gbox_cnt_o <= cnt_q;
      cnt_q      <= (cnt_q == 6'd32) ? 6'd0 : cnt_q + 6'd1;
      idle_ins_o <= load && !in_valid_i;
    end else begin
      out_dv_o   <= 1'b0;
      idle_ins_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aurora_tx_gearbox.sv
// Bench for aurora_tx_gearbox: bit-queue line model with a history-based
// scrambler, checked on a plain (SCRAMBLE=0) and a scrambling instance.
`timescale 1ns/1ps

module tb_aurora_tx_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, out_en, in_valid;
  logic [1:0]  in_header;
  logic [63:0] in_data;
  logic        rdy0, dv0, idle0, rdy1, dv1, idle1;
  logic [31:0] w0, w1;
  logic [5:0]  cnt0, cnt1;

  aurora_tx_gearbox #(.SCRAMBLE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .out_en_i(out_en), .in_valid_i(in_valid),
    .in_header_i(in_header), .in_data_i(in_data), .in_ready_o(rdy0),
    .out_data_o(w0), .out_dv_o(dv0), .gbox_cnt_o(cnt0), .idle_ins_o(idle0)
  );

  aurora_tx_gearbox #(.SCRAMBLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .out_en_i(out_en), .in_valid_i(in_valid),
    .in_header_i(in_header), .in_data_i(in_data), .in_ready_o(rdy1),
    .out_data_o(w1), .out_dv_o(dv1), .gbox_cnt_o(cnt1), .idle_ins_o(idle1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Line model: bits waiting to go out, oldest first.
  bit          mq0[$], mq1[$], hist[$], rxq[$];
  logic [65:0] blk_exp[$];
  logic [1:0]  src_h[$];
  logic [63:0] src_d[$];
  logic [31:0] exp_w0, exp_w1, ref_words[$];
  logic [5:0]  exp_cnt;
  int          m_cnt;
  bit          last_ready, last_idle;

  // Self-synchronous view: each output bit xors the line bits 39 and 58 back.
  function automatic logic [63:0] scramble(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 63; i >= 0; i--) begin
      o[i] = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
      hist.push_back(o[i]);
      void'(hist.pop_front());
    end
    return o;
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete(); rxq.delete(); blk_exp.delete();
    src_h.delete(); src_d.delete(); hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    exp_w0 = '0; exp_w1 = '0; exp_cnt = '0; m_cnt = 0;
  endtask

  task automatic drive(input bit en, input bit want);
    out_en   = en;
    in_valid = want && (src_h.size() > 0);
    if (in_valid) begin
      in_header = src_h[0];
      in_data   = src_d[0];
    end else begin
      in_header = 2'($urandom);
      in_data   = {$urandom, $urandom};
    end
  endtask

  task automatic step();
    bit          load, take;
    logic [65:0] b, rb, eb;
    #1;
    load = out_en && (mq0.size() < 32);
    take = load && in_valid;
    n_vec++;
    if (rdy0 !== take || rdy1 !== take) begin
      n_err++;
      $display("FAIL in_ready: got %b/%b want %b (F=%0d)", rdy0, rdy1, take, mq0.size());
    end
    if (load) begin
      b = take ? {in_header, in_data} : {2'b10, 64'h7800_0000_0000_0000};
      blk_exp.push_back(b);
      for (int i = 65; i >= 0; i--) mq0.push_back(b[i]);
      b[63:0] = scramble(b[63:0]);
      for (int i = 65; i >= 0; i--) mq1.push_back(b[i]);
    end
    if (out_en) begin
      for (int i = 31; i >= 0; i--) begin
        exp_w0[i] = mq0.pop_front();
        exp_w1[i] = mq1.pop_front();
      end
      exp_cnt = 6'(m_cnt);
      m_cnt   = (m_cnt + 1) % 33;
    end
    last_ready = take;
    last_idle  = load && !in_valid;
    @(posedge clk); #1;
    if (take) begin
      void'(src_h.pop_front());
      void'(src_d.pop_front());
    end
    n_vec++;
    if ({w0, dv0, cnt0, idle0} !== {exp_w0, out_en, exp_cnt, last_idle}) begin
      n_err++;
      $display("FAIL plain out: got d=%h dv=%b cnt=%0d idle=%b want d=%h dv=%b cnt=%0d idle=%b",
               w0, dv0, cnt0, idle0, exp_w0, out_en, exp_cnt, last_idle);
    end
    n_vec++;
    if ({w1, dv1, cnt1, idle1} !== {exp_w1, out_en, exp_cnt, last_idle}) begin
      n_err++;
      $display("FAIL scr out: got d=%h dv=%b cnt=%0d idle=%b want d=%h dv=%b cnt=%0d idle=%b",
               w1, dv1, cnt1, idle1, exp_w1, out_en, exp_cnt, last_idle);
    end
    // Rx-side reassembly of the plain stream into 66-bit blocks.
    if (out_en) begin
      for (int i = 31; i >= 0; i--) rxq.push_back(w0[i]);
      while (rxq.size() >= 66) begin
        for (int i = 65; i >= 0; i--) rb[i] = rxq.pop_front();
        n_vec++;
        if (blk_exp.size() == 0) begin
          n_err++;
          $display("FAIL rx block: got %h with no block pending", rb);
        end else begin
          eb = blk_exp.pop_front();
          if (rb !== eb) begin
            n_err++;
            $display("FAIL rx block: got %h want %h", rb, eb);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    src_h.push_back(2'b01); src_d.push_back(64'h1234);
    drive(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({w0, dv0, cnt0, idle0} !== 40'd0) begin
      n_err++;
      $display("FAIL reset plain: got d=%h dv=%b cnt=%0d idle=%b want all 0", w0, dv0, cnt0, idle0);
    end
    n_vec++;
    if ({w1, dv1, cnt1, idle1} !== 40'd0) begin
      n_err++;
      $display("FAIL reset scr: got d=%h dv=%b cnt=%0d idle=%b want all 0", w1, dv1, cnt1, idle1);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_order_idle();
    bit e;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b0);
      step();
      if (k == 0) begin
        n_vec++;
        if (w0 !== 32'h9E00_0000) begin
          n_err++;
          $display("FAIL first word: got %h want 9e000000", w0);
        end
      end
      if (k == 1) begin
        n_vec++;
        if (w0 !== 32'h0) begin
          n_err++;
          $display("FAIL second word: got %h want 00000000", w0);
        end
      end
      e = ((k % 33) % 2 == 0) && ((k % 33) <= 30);
      n_vec++;
      if (idle0 !== e) begin
        n_err++;
        $display("FAIL idle pulse word %0d: got %b want %b", k, idle0, e);
      end
    end
  endtask

  task automatic test_ready_pattern();
    int nr, nr33;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      src_h.push_back(2'b01);
      src_d.push_back(64'(i));
    end
    ref_words.delete();
    nr = 0; nr33 = 0;
    for (int k = 0; k < 132; k++) begin
      drive(1'b1, 1'b1);
      step();
      if (last_ready) nr++;
      if (k == 32) begin
        nr33 = nr;
        n_vec++;
        if (cnt0 !== 6'd32) begin
          n_err++;
          $display("FAIL gbox_cnt top: got %0d want 32", cnt0);
        end
      end
      if (k == 33) begin
        n_vec++;
        if (cnt0 !== 6'd0) begin
          n_err++;
          $display("FAIL gbox_cnt wrap: got %0d want 0", cnt0);
        end
      end
      ref_words.push_back(w0);
    end
    n_vec++;
    if (nr33 != 16) begin
      n_err++;
      $display("FAIL ready per period: got %0d want 16", nr33);
    end
    n_vec++;
    if (nr != 64 || src_h.size() != 0) begin
      n_err++;
      $display("FAIL ready total: got %0d (left %0d) want 64 (left 0)", nr, src_h.size());
    end
  endtask

  task automatic test_throttled();
    int idx;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      src_h.push_back(2'b01);
      src_d.push_back(64'(i));
    end
    idx = 0;
    for (int s = 0; s < 132 * 8; s++) begin
      drive(s % 8 == 0, 1'b1);
      step();
      if (s % 8 == 0) begin
        n_vec++;
        if (idx >= ref_words.size() || w0 !== ref_words[idx]) begin
          n_err++;
          $display("FAIL throttled word %0d: got %h want %h", idx, w0,
                   (idx < ref_words.size()) ? ref_words[idx] : 32'hx);
        end
        idx++;
      end
    end
  endtask

  task automatic test_scrambler();
    logic [31:0] wa, wb;
    do_reset();
    src_h.push_back(2'b01);
    src_d.push_back(64'h0);
    drive(1'b1, 1'b1);
    step();
    wa = w1;
    drive(1'b1, 1'b0);
    step();
    wb = w1;
    n_vec++;
    if (wa !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL scr word0: got %h want 40000000", wa);
    end
    n_vec++;
    if (wb[31:23] !== 9'd0 || wb[22] !== 1'b1) begin
      n_err++;
      $display("FAIL scr word1: got bits31..22=%b want 0000000001", wb[31:22]);
    end
  endtask

  task automatic test_gaps();
    int  gap, loads, idles, guard;
    bit  ld;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      src_h.push_back(2'($urandom));
      src_d.push_back({$urandom, $urandom});
    end
    gap = 0; loads = 0; idles = 0; guard = 0;
    while (src_h.size() > 0 && guard < 200) begin
      ld = mq0.size() < 32;
      if (ld && loads == 5) gap = 3;
      drive(1'b1, !(ld && gap > 0));
      step();
      if (ld) begin
        loads++;
        if (gap > 0) gap--;
      end
      if (idle0 === 1'b1) idles++;
      guard++;
    end
    n_vec++;
    if (idles != 3 || guard >= 200) begin
      n_err++;
      $display("FAIL gap idles: got %0d (cycles %0d) want 3", idles, guard);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      src_h.push_back(2'($urandom));
      src_d.push_back({$urandom, $urandom});
    end
    guard = 0;
    do begin
      drive(1'b1, 1'b1);
      step();
      guard++;
    end while (mq0.size() != 30 && guard < 100);
    n_vec++;
    if (guard >= 100) begin
      n_err++;
      $display("FAIL reach F=30: got F=%0d want 30", mq0.size());
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({w0, dv0, cnt0, idle0, w1, dv1, cnt1, idle1} !== 80'd0) begin
      n_err++;
      $display("FAIL async reset: got d=%h/%h dv=%b/%b cnt=%0d/%0d want all 0",
               w0, w1, dv0, dv1, cnt0, cnt1);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0);
      step();
      if (k == 0) begin
        n_vec++;
        if (w0 !== 32'h9E00_0000 || cnt0 !== 6'd0) begin
          n_err++;
          $display("FAIL restart word: got %h cnt=%0d want 9e000000 cnt=0", w0, cnt0);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (src_h.size() < 4) begin
        src_h.push_back(2'($urandom));
        src_d.push_back({$urandom, $urandom});
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    out_en = 1'b0; in_valid = 1'b0; in_header = '0; in_data = '0;
    #1;
    test_reset();
    test_order_idle();
    test_ready_pattern();
    test_throttled();
    test_scrambler();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
